// File: rtl/dogx_gain_combiner_pkg.sv
// dogx_conv_pkg -- shared types and helpers for the gain combiner.
//   conv_state_e : selection FSM states (STEADY, FADE).
//   sat_abs      : magnitude of a w-bit signed value carried in 32 bits;
//                  the most negative w-bit code saturates to 2^(w-1)-1 so the
//                  result always fits back into w unsigned bits minus one.
package dogx_conv_pkg;

   typedef enum logic {
      STEADY = 1'b0,
      FADE   = 1'b1
   } conv_state_e;

   function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                           input int                 w);
      logic signed [31:0] lim;
      lim = (32'sd1 <<< (w - 1)) - 32'sd1;
      if (x < -lim)
         sat_abs = lim;
      else if (x < 0)
         sat_abs = -x;
      else
         sat_abs = x;
   endfunction

endpackage

// File: rtl/dogx_gain_combiner_if.sv
// dogx_gain_combiner_if -- sample bus between the converter front end and the
// gain combiner.
//   ch_data          : N_CH packed signed samples, channel c at [c*W_IN +: W_IN]
//   sel_out          : channel currently selected by the combiner
//   fading           : the word on converter_output is a crossfade mix
//   out_valid        : one-cycle strobe for a new converter_output word
//   converter_output : signed combined sample
// master = front end (drives samples), slave = combiner (drives results).
interface dogx_gain_combiner_if #(
   parameter int N_CH  = 3,
   parameter int W_IN  = 9,
   parameter int W_OUT = 13
);
   localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH*W_IN-1:0]    ch_data;
   logic [SEL_W-1:0]        sel_out;
   logic                    fading;
   logic                    out_valid;
   logic signed [W_OUT-1:0] converter_output;

   modport master (
      output ch_data,
      input  sel_out,
      input  fading,
      input  out_valid,
      input  converter_output
   );

   modport slave (
      input  ch_data,
      output sel_out,
      output fading,
      output out_valid,
      output converter_output
   );
endinterface

// File: rtl/dogx_gain_combiner_channel_crossfader.sv
// channel_crossfader -- combinational linear mix of two gain-aligned samples.
//   src  : sample being faded out
//   dst  : sample being faded in
//   step : fade position 0 .. 2^FADE_LOG2-1
//   mix  : (src*(2^F-step) + dst*step) >>> F, floor (truncating) division
module channel_crossfader #(
   parameter int W_OUT     = 13,
   parameter int FADE_LOG2 = 3
) (
   input  logic signed [W_OUT-1:0]   src,
   input  logic signed [W_OUT-1:0]   dst,
   input  logic        [FADE_LOG2-1:0] step,
   output logic signed [W_OUT-1:0]   mix
);
   import dogx_conv_pkg::*;

   // One spare bit above W_OUT+F so the weighted sum never wraps.
   localparam int PW = W_OUT + FADE_LOG2 + 1;
   localparam logic signed [PW-1:0] FULL = PW'(1 << FADE_LOG2);

   logic signed [PW-1:0] src_x;
   logic signed [PW-1:0] dst_x;
   logic signed [PW-1:0] w_src;
   logic signed [PW-1:0] w_dst;
   logic signed [PW-1:0] acc;

   function automatic logic signed [W_OUT-1:0] trunc_shift(input logic signed [PW-1:0] a);
      return W_OUT'(a >>> FADE_LOG2);
   endfunction

   always_comb begin
      src_x = {{(FADE_LOG2 + 1){src[W_OUT-1]}}, src};
      dst_x = {{(FADE_LOG2 + 1){dst[W_OUT-1]}}, dst};
      w_dst = {{(W_OUT + 1){1'b0}}, step};
      w_src = FULL - w_dst;
      acc   = (src_x * w_src) + (dst_x * w_dst);
      mix   = trunc_shift(acc);
   end

endmodule

// File: rtl/dogx_gain_combiner.sv
// dogx_gain_combiner -- N-channel gain combiner with hysteresis/timeout
// channel selection and optional linear crossfade between channels.
//   CLK_24M   : sole clock
//   reset     : synchronous, active-high
//   th_high   : up-switch magnitude threshold (unsigned)
//   th_low    : down-switch magnitude threshold (unsigned)
//   timeout   : extra low ticks required before a down switch
//   use_fade  : 1 = crossfade on switch, 0 = hard switch
//   force_en  : override automatic selection with force_ch
//   force_ch  : forced channel, clamped to N_CH-1
//   bus       : slave side of the sample bus (ch_data in, results out)
// All selection state advances only on the internal sample tick (one per DIV
// clocks). The word emitted at a tick is computed from the state before that
// tick's decision, so a decision shows in the sample one tick later.
module dogx_gain_combiner
   import dogx_conv_pkg::*;
#(
   parameter int N_CH      = 3,
   parameter int W_IN      = 9,
   parameter int GAIN_STEP = 2,
   parameter int W_OUT     = 13,
   parameter int DIV       = 8,
   parameter int FADE_LOG2 = 3,
   parameter int TIMEOUT_W = 5
) (
   input  logic                      CLK_24M,
   input  logic                      reset,
   input  logic [W_IN-1:0]           th_high,
   input  logic [W_IN-1:0]           th_low,
   input  logic [TIMEOUT_W-1:0]      timeout,
   input  logic                      use_fade,
   input  logic                      force_en,
   input  logic [$clog2(N_CH)-1:0]   force_ch,
   dogx_gain_combiner_if.slave       bus
);

   localparam int SEL_W = $clog2(N_CH);
   localparam int DIV_W = $clog2(DIV);
   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_CH - 1);

   logic [DIV_W-1:0]        div_cnt;
   logic                    tick;

   conv_state_e             state, state_nxt;
   logic [SEL_W-1:0]        sel, sel_nxt;
   logic [SEL_W-1:0]        src, src_nxt;
   logic [FADE_LOG2-1:0]    step, step_nxt;
   logic [TIMEOUT_W-1:0]    low_cnt, low_nxt;

   logic signed [W_IN-1:0]  ch_s [N_CH];
   logic signed [W_OUT-1:0] ext  [N_CH];
   logic signed [W_IN-1:0]  ch_sel;
   logic signed [W_OUT-1:0] ext_sel;
   logic signed [W_OUT-1:0] ext_src;
   logic signed [W_OUT-1:0] mix_word;
   logic [W_IN-1:0]         mag;
   logic                    mag_low;
   logic                    up_req;
   logic                    down_req;
   logic [SEL_W-1:0]        force_sel;

   logic signed [W_OUT-1:0] out_nxt;
   logic                    fading_nxt;
   logic signed [W_OUT-1:0] out_word_p1;
   logic                    fading_p1;
   logic                    vld_p1;

   // Sample-rate divider.
   assign tick = (div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge CLK_24M) begin
      if (reset)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // Gain alignment and selection muxes. In FADE, sel already holds the
   // destination channel, so the monitored magnitude is the destination's.
   always_comb begin
      ext_sel = '0;
      ext_src = '0;
      ch_sel  = '0;
      for (int c = 0; c < N_CH; c++) begin
         ch_s[c] = $signed(bus.ch_data[c*W_IN +: W_IN]);
         ext[c]  = W_OUT'(ch_s[c]) <<< (c * GAIN_STEP);
         if (sel == SEL_W'(c)) begin
            ext_sel = ext[c];
            ch_sel  = ch_s[c];
         end
         if (src == SEL_W'(c))
            ext_src = ext[c];
      end
   end

   always_comb begin
      mag       = W_IN'(sat_abs(32'(ch_sel), W_IN));
      mag_low   = (mag < th_low);
      up_req    = (mag >= th_high) && (sel < SEL_MAX);
      down_req  = mag_low && (low_cnt == timeout) && (sel != '0);
      force_sel = (force_ch > SEL_MAX) ? SEL_MAX : force_ch;
   end

   channel_crossfader #(
      .W_OUT     (W_OUT),
      .FADE_LOG2 (FADE_LOG2)
   ) u_xfade (
      .src  (ext_src),
      .dst  (ext_sel),
      .step (step),
      .mix  (mix_word)
   );

   // Next-state logic. up_req is tested first so it wins over down_req.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      src_nxt   = src;
      step_nxt  = step;
      low_nxt   = low_cnt;
      if (tick) begin
         if (force_en) begin
            sel_nxt   = force_sel;
            state_nxt = STEADY;
            step_nxt  = '0;
            low_nxt   = '0;
         end else begin
            case (state)
               STEADY: begin
                  if (up_req || down_req) begin
                     sel_nxt = up_req ? (sel + 1'b1) : (sel - 1'b1);
                     low_nxt = '0;
                     if (use_fade) begin
                        src_nxt   = sel;
                        step_nxt  = '0;
                        state_nxt = FADE;
                     end
                  end else if (mag_low) begin
                     if (low_cnt != '1)
                        low_nxt = low_cnt + 1'b1;
                  end else begin
                     low_nxt = '0;
                  end
               end
               FADE: begin
                  // Low-level counting is suspended; only an up request can
                  // abort the fade, jumping straight past the destination.
                  low_nxt = '0;
                  if (up_req) begin
                     sel_nxt   = sel + 1'b1;
                     step_nxt  = '0;
                     state_nxt = STEADY;
                  end else begin
                     step_nxt = step + 1'b1;
                     if (step == '1)
                        state_nxt = STEADY;
                  end
               end
               default: state_nxt = STEADY;
            endcase
         end
      end
   end

   // Output word for this tick, from the pre-decision state.
   always_comb begin
      out_nxt    = (state == FADE) ? mix_word : ext_sel;
      fading_nxt = (state == FADE);
   end

   // State registers.
   always_ff @(posedge CLK_24M) begin
      if (reset) begin
         state   <= STEADY;
         sel     <= '0;
         step    <= '0;
         low_cnt <= '0;
      end else begin
         state   <= state_nxt;
         sel     <= sel_nxt;
         step    <= step_nxt;
         low_cnt <= low_nxt;
      end
   end

   always_ff @(posedge CLK_24M) begin
      src <= src_nxt;
   end

   // Stage p1: registered output word, visible the cycle after the tick.
   always_ff @(posedge CLK_24M) begin
      if (reset) begin
         vld_p1      <= 1'b0;
         fading_p1   <= 1'b0;
         out_word_p1 <= '0;
      end else begin
         vld_p1 <= tick;
         if (tick) begin
            fading_p1   <= fading_nxt;
            out_word_p1 <= out_nxt;
         end
      end
   end

   assign bus.sel_out          = sel;
   assign bus.fading           = fading_p1;
   assign bus.out_valid        = vld_p1;
   assign bus.converter_output = out_word_p1;

endmodule

// File: tb/tb_dogx_gain_combiner.sv
module tb_dogx_gain_combiner;

   localparam int N_CH      = 3;
   localparam int W_IN      = 9;
   localparam int GAIN_STEP = 2;
   localparam int W_OUT     = 13;
   localparam int DIV       = 8;
   localparam int FADE_LOG2 = 3;
   localparam int TIMEOUT_W = 5;
   localparam int FADE_LEN  = 1 << FADE_LOG2;
   localparam int LOW_MAX   = (1 << TIMEOUT_W) - 1;

   logic                 CLK_24M = 1'b0;
   logic                 reset;
   logic [W_IN-1:0]      th_high;
   logic [W_IN-1:0]      th_low;
   logic [TIMEOUT_W-1:0] timeout;
   logic                 use_fade;
   logic                 force_en;
   logic [1:0]           force_ch;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   // reference model state
   int m_cnt = 0, m_sel = 0, m_src = 0, m_step = 0, m_low = 0;
   bit m_fade = 1'b0;
   bit e_valid = 1'b0, e_fading = 1'b0;
   int e_out = 0;

   always #5 CLK_24M = ~CLK_24M;

   dogx_gain_combiner_if #(.N_CH(N_CH), .W_IN(W_IN), .W_OUT(W_OUT)) bus ();

   dogx_gain_combiner #(
      .N_CH(N_CH), .W_IN(W_IN), .GAIN_STEP(GAIN_STEP), .W_OUT(W_OUT),
      .DIV(DIV), .FADE_LOG2(FADE_LOG2), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .CLK_24M(CLK_24M), .reset(reset), .th_high(th_high), .th_low(th_low),
      .timeout(timeout), .use_fade(use_fade), .force_en(force_en),
      .force_ch(force_ch), .bus(bus)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int chv(input int c);
      logic signed [W_IN-1:0] s;
      s = bus.ch_data[c*W_IN +: W_IN];
      return int'(s);
   endfunction

   function automatic int ext(input int c);
      return chv(c) * (1 << (c * GAIN_STEP));
   endfunction

   task automatic set_ch(input int a, input int b, input int c);
      bus.ch_data = {W_IN'(c), W_IN'(b), W_IN'(a)};
   endtask

   // One sample tick of the behavioural model.
   task automatic model_tick();
      int mag, nsel;
      bit up, down;
      if (m_fade)
         e_out = (ext(m_src) * (FADE_LEN - m_step) + ext(m_sel) * m_step) >>> FADE_LOG2;
      else
         e_out = ext(m_sel);
      e_fading = m_fade;
      e_valid  = 1'b1;
      mag = chv(m_sel);
      if (mag < 0) mag = -mag;
      if (mag > 255) mag = 255;
      up   = (mag >= int'(th_high)) && (m_sel < N_CH - 1);
      down = (mag < int'(th_low)) && (m_low == int'(timeout)) && (m_sel > 0);
      if (force_en) begin
         m_sel  = (int'(force_ch) > N_CH - 1) ? N_CH - 1 : int'(force_ch);
         m_fade = 1'b0;
         m_low  = 0;
      end else if (m_fade) begin
         m_low = 0;
         if (up) begin
            m_sel  = m_sel + 1;
            m_fade = 1'b0;
         end else if (m_step == FADE_LEN - 1) begin
            m_fade = 1'b0;
         end else begin
            m_step = m_step + 1;
         end
      end else if (up || down) begin
         nsel  = up ? m_sel + 1 : m_sel - 1;
         m_low = 0;
         if (use_fade) begin
            m_src  = m_sel;
            m_fade = 1'b1;
            m_step = 0;
         end
         m_sel = nsel;
      end else if (mag < int'(th_low)) begin
         m_low = (m_low < LOW_MAX) ? m_low + 1 : LOW_MAX;
      end else begin
         m_low = 0;
      end
   endtask

   always @(posedge CLK_24M) begin
      if (reset) begin
         m_cnt = 0; m_sel = 0; m_fade = 1'b0; m_step = 0; m_low = 0;
         e_valid = 1'b0;
      end else begin
         e_valid = 1'b0;
         if (m_cnt == DIV - 1)
            model_tick();
         m_cnt = (m_cnt + 1) % DIV;
      end
   end

   // Continuous comparison against the model.
   always @(negedge CLK_24M) begin
      if (run_cmp) begin
         check("out_valid", int'(bus.out_valid), int'(e_valid));
         check("sel_out", int'(bus.sel_out), m_sel);
         if (e_valid) begin
            check("converter_output", int'(bus.converter_output), e_out);
            check("fading", int'(bus.fading), int'(e_fading));
         end
      end
   end

   task automatic next_out(output int v, output int s, output int f);
      int n;
      n = 0;
      do begin
         @(negedge CLK_24M);
         n++;
      end while (!bus.out_valid && n < 20);
      check("out_valid_wait", int'(bus.out_valid), 1);
      v = int'(bus.converter_output);
      s = int'(bus.sel_out);
      f = int'(bus.fading);
   endtask

   // Reset for 3 clocks with neutral settings; checks zeroed outputs and the
   // out_valid cadence after release (cycle 1 = first cycle after release).
   task automatic do_reset();
      int first, second;
      @(negedge CLK_24M);
      reset = 1'b1;
      th_high = 9'd511; th_low = 9'd0; timeout = '0;
      use_fade = 1'b0; force_en = 1'b0; force_ch = 2'd0;
      set_ch(0, 0, 0);
      @(negedge CLK_24M);
      @(negedge CLK_24M);
      check("rst_sel_out", int'(bus.sel_out), 0);
      check("rst_fading", int'(bus.fading), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_output", int'(bus.converter_output), 0);
      @(posedge CLK_24M);
      #1 reset = 1'b0;
      first = 0; second = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge CLK_24M);
         if (bus.out_valid) begin
            if (first == 0) first = i;
            else if (second == 0) second = i;
         end
      end
      check("first_valid_cycle", first, 9);
      check("second_valid_cycle", second, 17);
   endtask

   int v, s, f;
   int exp_fade [10] = '{200, 200, 180, 160, 140, 120, 100, 80, 60, 40};

   initial begin
      reset = 1'b1;
      th_high = 9'd511; th_low = 9'd0; timeout = '0;
      use_fade = 1'b0; force_en = 1'b0; force_ch = 2'd0;
      set_ch(0, 0, 0);
      @(posedge CLK_24M);
      #1 run_cmp = 1'b1;
      do_reset();

      // hard up switch
      th_high = 9'd200; set_ch(250, 60, 0);
      next_out(v, s, f);
      check("hard_decision_out", v, 250);
      check("hard_decision_sel", s, 1);
      next_out(v, s, f);
      check("hard_next_out", v, 240);

      // crossfade 0 -> 1
      do_reset();
      use_fade = 1'b1; th_high = 9'd200; set_ch(200, 10, 0);
      for (int i = 0; i < 10; i++) begin
         next_out(v, s, f);
         check("fade_out", v, exp_fade[i]);
         check("fade_flag", f, (i >= 1 && i <= 8) ? 1 : 0);
         check("fade_sel", s, 1);
      end

      // reset mid-fade
      do_reset();
      use_fade = 1'b1; th_high = 9'd200; set_ch(200, 10, 0);
      repeat (3) next_out(v, s, f);
      do_reset();

      // timeout down switch
      th_low = 9'd30; timeout = 5'd4; set_ch(0, 10, 0);
      force_en = 1'b1; force_ch = 2'd1;
      next_out(v, s, f);
      check("force_to_1", s, 1);
      force_en = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         next_out(v, s, f);
         check("timeout_sel", s, (k < 5) ? 1 : 0);
      end
      force_en = 1'b1;
      next_out(v, s, f);
      force_en = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         set_ch(0, (k == 3) ? 35 : 10, 0);
         next_out(v, s, f);
         check("timeout_restart_sel", s, (k < 8) ? 1 : 0);
      end

      // force during a fade
      do_reset();
      use_fade = 1'b1; th_high = 9'd200; set_ch(200, 10, -7);
      repeat (3) next_out(v, s, f);
      force_en = 1'b1; force_ch = 2'd3;
      next_out(v, s, f);
      check("force_mid_fade_out", v, 160);
      check("force_sel", s, 2);
      next_out(v, s, f);
      check("force_after_out", v, -112);
      check("force_after_fading", f, 0);
      check("force_after_sel", s, 2);
      force_en = 1'b0;

      // saturating magnitude of the most negative code
      do_reset();
      th_high = 9'd255; set_ch(-256, 3, 0);
      next_out(v, s, f);
      check("satabs_out", v, -256);
      check("satabs_sel", s, 1);
      next_out(v, s, f);
      check("satabs_next_out", v, 12);

      // randomized operation against the model
      do_reset();
      for (int n = 0; n < 300; n++) begin
         if (n == 150) do_reset();
         if ($urandom_range(0, 2) == 0) begin
            set_ch(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                   int'($urandom_range(0, 511)));
            th_high  = W_IN'(60 + $urandom_range(0, 200));
            th_low   = W_IN'($urandom_range(0, 90));
            timeout  = TIMEOUT_W'($urandom_range(0, 3));
            use_fade = ($urandom_range(0, 3) != 0);
            force_en = ($urandom_range(0, 15) == 0);
            force_ch = 2'($urandom_range(0, 3));
         end
         next_out(v, s, f);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
